// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-beat APB initiator with a valid/ready command port,
//            a one-cycle response strobe and an optional wait-state timeout.
// Revision : 1.0
// ============================================================================
module apb_master #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                  pClk,
  input  logic                  pReset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  pSelect,
  output logic                  pEnable,
  output logic                  pWrite,
  output logic [ADDR_WIDTH-1:0] pAddress,
  output logic [DATA_WIDTH-1:0] pWData,
  input  logic [DATA_WIDTH-1:0] pRData,
  input  logic                  pReady
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic w_accept;
  logic w_done;
  logic w_abort;
  logic w_to_hit;

  // A TIMEOUT of zero removes the abort path entirely.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
      assign w_to_hit = ({16'd0, cnt_q} == TO_LAST);
    end else begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end
  endgenerate

  assign cmd_ready = (state_q == S_IDLE) || ((state_q == S_ACCESS) && pReady);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = (state_q == S_ACCESS) && pReady;
  assign w_abort   = (state_q == S_ACCESS) && !pReady && w_to_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = w_done || w_abort;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = 16'd0;
      end
      S_ACCESS: begin
        if (pReady) begin
          state_d     = w_accept ? S_SETUP : S_IDLE;
          rsp_rdata_d = pwrite_q ? '0 : pRData;
          rsp_err_d   = 1'b0;
        end else if (w_to_hit) begin
          state_d     = S_IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (w_accept) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end
    end
  end

  assign pSelect   = (state_q != S_IDLE);
  assign pEnable   = (state_q == S_ACCESS);
  assign pWrite    = pwrite_q;
  assign pAddress  = paddr_q;
  assign pWData    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Vector table plus hand sequences for apb_master, with a response
//            scoreboard. Revision : 1.0
// ============================================================================
module tb_apb_master;

  localparam int AW = 33;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          pClk = 1'b0;
  logic          pReset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          pSelect, pEnable, pWrite, pReady;
  logic [AW-1:0] pAddress;
  logic [DW-1:0] pWData, pRData;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pClk(pClk), .pReset(pReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
    .pAddress(pAddress), .pWData(pWData), .pRData(pRData), .pReady(pReady)
  );

  always #5 pClk = ~pClk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          to;
    logic [DW-1:0] bus_rdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  rsp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pClk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  // One isolated transfer; a bus cycle is sampled at each negedge.
  task automatic run_vec(input vec_t v);
    int n;
    @(negedge pClk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; pReady = 1'b0;
    #1 chk("ready_idle", cmd_ready, 1);
    @(posedge pClk);
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge pClk);
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_write = ~v.wr;
    chk("setup_sel", {pSelect, pEnable}, 2'b10);
    chk("setup_addr", pAddress, v.addr);
    chk("setup_wdata", pWData, v.wdata);
    chk("setup_write", pWrite, v.wr);
    chk("setup_ready", cmd_ready, 0);
    pReady = 1'b1;  // must be ignored during SETUP
    n = v.to ? TO : v.waits + 1;
    for (int k = 0; k < n; k++) begin
      @(negedge pClk);
      chk("access_sel", {pSelect, pEnable}, 2'b11);
      chk("access_addr", pAddress, v.addr);
      chk("rsp_quiet", rsp_valid, 0);
      pReady = (!v.to && k == v.waits);
      pRData = pReady ? v.bus_rdata : 8'hEE;
      #1 chk("access_ready", cmd_ready, pReady);
    end
    @(negedge pClk);
    chk("rsp_strobe", rsp_valid, 1);
    chk("end_sel", {pSelect, pEnable}, 2'b00);
    pReady = 1'b0;
    @(negedge pClk);
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  // Write then read with cmd_valid held; w1 wait states on the write.
  task automatic b2b(input int w1);
    @(negedge pClk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 33'h20; cmd_wdata = 8'h11; pReady = 1'b0;
    #1 chk("b2b_ready0", cmd_ready, 1);
    @(posedge pClk);
    sb_q.push_back('{rdata: 8'h00, err: 1'b0});
    @(negedge pClk);
    chk("b2b_setup1", {pSelect, pEnable}, 2'b10);
    chk("b2b_addr1", pAddress, 33'h20);
    cmd_write = 1'b0; cmd_addr = 33'h24; cmd_wdata = 8'h99;
    #1 chk("b2b_busy_setup", cmd_ready, 0);
    for (int k = 0; k <= w1; k++) begin
      @(negedge pClk);
      chk("b2b_access1", {pSelect, pEnable}, 2'b11);
      chk("b2b_hold_addr", pAddress, 33'h20);
      chk("b2b_hold_wdata", pWData, 8'h11);
      pReady = (k == w1); pRData = 8'hEE;
      #1 chk("b2b_ready_access", cmd_ready, (k == w1));
    end
    @(posedge pClk);
    sb_q.push_back('{rdata: 8'h5A, err: 1'b0});
    @(negedge pClk);
    chk("b2b_rsp1", rsp_valid, 1);
    chk("b2b_setup2", {pSelect, pEnable}, 2'b10);
    chk("b2b_addr2", pAddress, 33'h24);
    chk("b2b_write2", pWrite, 0);
    cmd_valid = 1'b0; pReady = 1'b0;
    @(negedge pClk);
    chk("b2b_access2", {pSelect, pEnable}, 2'b11);
    chk("b2b_gap", rsp_valid, 0);
    pReady = 1'b1; pRData = 8'h5A;
    @(negedge pClk);
    chk("b2b_rsp2", rsp_valid, 1);
    chk("b2b_end", pSelect, 0);
    pReady = 1'b0;
    @(negedge pClk);
    chk("b2b_quiet", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 33'h000000004, 8'hA5, 0, 1'b0, 8'h77, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 33'h000000008, 8'h00, 3, 1'b0, 8'h3C, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 33'h100000001, 8'h42, 0, 1'b0, 8'hC3, 8'hC3, 1'b0};
    vecs[3] = '{1'b1, 33'h1FFFFFFFF, 8'h5A, 2, 1'b0, 8'h99, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 33'h000000010, 8'h00, 0, 1'b1, 8'hAA, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 33'h000000014, 8'h00, 0, 1'b0, 8'h81, 8'h81, 1'b0};
    vecs[6] = '{1'b1, 33'h000000018, 8'hFF, 0, 1'b1, 8'h55, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 33'h0000000FC, 8'h00, 1, 1'b0, 8'h00, 8'h00, 1'b0};

    pReset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; pReady = 1'b0; pRData = '0;
    #2;
    chk("rst_bus", {pSelect, pEnable, pWrite}, 3'b000);
    chk("rst_addr", pAddress, 0);
    chk("rst_wdata", pWData, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    repeat (2) @(negedge pClk);
    pReset = 1'b0;
    @(negedge pClk);
    chk("rst_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    b2b(0);
    b2b(2);

    // Reset while in ACCESS kills the transfer without a response.
    @(negedge pClk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 33'h30; pReady = 1'b0;
    @(negedge pClk);
    cmd_valid = 1'b0;
    @(negedge pClk);
    chk("kill_access", {pSelect, pEnable}, 2'b11);
    #1 pReset = 1'b1;
    #1;
    chk("kill_bus", {pSelect, pEnable}, 2'b00);
    chk("kill_addr", pAddress, 0);
    @(negedge pClk);
    chk("kill_no_rsp", rsp_valid, 0);
    pReset = 1'b0;
    @(negedge pClk);
    chk("kill_ready", cmd_ready, 1);
    chk("kill_no_rsp2", rsp_valid, 0);
    run_vec('{1'b1, 33'h000000034, 8'h6B, 1, 1'b0, 8'h00, 8'h00, 1'b0});

    repeat (3) @(negedge pClk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
